// File: rtl/sram2rw_port_arbiter.sv
// sram2rw_port_arbiter: round-robin sharing of a dual-port 64x8 SRAM macro between NREQ requesters
module sram2rw_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          resp_valid,
  output logic [NREQ*DATA_W-1:0]   resp_rdata,
  output logic                     mem_ce1,
  output logic                     mem_ce2,
  output logic                     mem_csb1,
  output logic                     mem_csb2,
  output logic                     mem_web1,
  output logic                     mem_web2,
  output logic                     mem_oeb1,
  output logic                     mem_oeb2,
  output logic [ADDR_W-1:0]        mem_a1,
  output logic [ADDR_W-1:0]        mem_a2,
  output logic [DATA_W-1:0]        mem_i1,
  output logic [DATA_W-1:0]        mem_i2,
  input  logic [DATA_W-1:0]        mem_o1,
  input  logic [DATA_W-1:0]        mem_o2
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [ADDR_W-1:0] addr [NREQ];
  logic [DATA_W-1:0] wdata [NREQ];
  logic [IW-1:0] rr_q, rr_d, g1, g2, own1_q, own1_d, own2_q, own2_d;
  logic g1_v, g2_v, gr1, gr2, rv1_q, rv1_d, rv2_q, rv2_d;
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction
  assign mem_ce1 = clock;
  assign mem_ce2 = clock;
  // Unpack the per-requester address and write-data slices
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end
  // Circular search from rr_q: port 1 takes the first valid requester, port 2 the next one that does not collide with it
  always_comb begin
    logic [IW-1:0] jj;
    int j;
    g1_v = 1'b0;
    g1 = '0;
    g2_v = 1'b0;
    g2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_q) + k;
      j = j >= NREQ ? j - NREQ : j;
      jj = IW'(j);
      if (!g1_v && req_valid[jj]) begin
        g1_v = 1'b1;
        g1 = jj;
      end else if (g1_v && !g2_v && req_valid[jj] &&
                   !(addr[jj] == addr[g1] && (req_write[jj] || req_write[g1]))) begin
        g2_v = 1'b1;
        g2 = jj;
      end
    end
  end
  // Drive grants, macro controls, next pointer and read-owner tracking; reset blanks every grant
  always_comb begin
    gr1 = g1_v & ~reset;
    gr2 = g2_v & ~reset;
    req_ready = '0;
    if (gr1) req_ready[g1] = 1'b1;
    if (gr2) req_ready[g2] = 1'b1;
    mem_csb1 = ~gr1;
    mem_web1 = ~(gr1 & req_write[g1]);
    mem_oeb1 = ~(gr1 & ~req_write[g1]);
    mem_a1   = gr1 ? addr[g1] : '0;
    mem_i1   = (gr1 && req_write[g1]) ? wdata[g1] : '0;
    mem_csb2 = ~gr2;
    mem_web2 = ~(gr2 & req_write[g2]);
    mem_oeb2 = ~(gr2 & ~req_write[g2]);
    mem_a2   = gr2 ? addr[g2] : '0;
    mem_i2   = (gr2 && req_write[g2]) ? wdata[g2] : '0;
    rr_d   = gr2 ? wrap_inc(g2) : gr1 ? wrap_inc(g1) : rr_q;
    rv1_d  = gr1 & ~req_write[g1];
    rv2_d  = gr2 & ~req_write[g2];
    own1_d = g1;
    own2_d = g2;
  end
  // Pointer and read-owner registers; reset drops in-flight responses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q   <= '0;
      rv1_q  <= 1'b0;
      rv2_q  <= 1'b0;
      own1_q <= '0;
      own2_q <= '0;
    end else begin
      rr_q   <= rr_d;
      rv1_q  <= rv1_d;
      rv2_q  <= rv2_d;
      own1_q <= own1_d;
      own2_q <= own2_d;
    end
  end
  // Route each port's read data to the requester that owned it last cycle
  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rv1_q && own1_q == IW'(i)) begin
        resp_valid[i] = 1'b1;
        resp_rdata[i*DATA_W +: DATA_W] = mem_o1;
      end
      if (rv2_q && own2_q == IW'(i)) begin
        resp_valid[i] = 1'b1;
        resp_rdata[i*DATA_W +: DATA_W] = mem_o2;
      end
    end
  end
endmodule
